// File: rtl/req_ack_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : req_ack_pkg
//  Description : Shared types for the Req/Ack command responder.
//                cmd_e   - command encoding carried on Cmd
//                state_e - responder handshake state
//  Revision    : 1.0 - initial release
// ============================================================================
package req_ack_pkg;

  typedef enum logic [1:0] {
    NOP  = 2'b00,
    LOAD = 2'b01,
    INC  = 2'b10,
    READ = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    ACK  = 2'b10
  } state_e;

endpackage
`default_nettype wire

// File: rtl/req_ack_responder_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mod_counter
//  Description : Modulo-MODULO counter with load and increment strobes.
//                A load whose value is >= MODULO is refused (counter holds)
//                and flagged on o_load_bad.
//  Ports       : clk        - clock, rising edge
//                rst_n      - asynchronous active-low reset (q -> 0)
//                i_load     - load strobe (i_d applied when legal)
//                i_inc      - increment strobe, wraps MODULO-1 -> 0
//                i_d        - load value
//                o_q        - counter value
//                o_load_bad - i_d is out of range (combinational on i_d)
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_counter #(
  parameter int WIDTH  = 4,
  parameter int MODULO = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_inc,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic             o_load_bad
);

  // One extra bit so MODULO == 2**WIDTH is representable.
  localparam logic [WIDTH:0]   c_mod = (WIDTH+1)'(MODULO);
  localparam logic [WIDTH-1:0] c_top = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] r_q;

  assign o_load_bad = ({1'b0, i_d} >= c_mod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      if (!o_load_bad) begin
        r_q <= i_d;
      end
    end else if (i_inc) begin
      r_q <= (r_q == c_top) ? '0 : r_q + WIDTH'(1);
    end
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/req_ack_responder.sv
`default_nettype none
// ============================================================================
//  Module      : req_ack_responder
//  Description : Target side of the Req/Ack command handshake. A request is
//                captured in IDLE, executed on the modulo counter on the edge
//                that enters ACK, and acknowledged with a one-cycle Ack pulse
//                ACK_LAT cycles after Req was sampled.
//  Ports       : CLK   - clock, rising edge
//                MR_n  - master reset, asynchronous active-low
//                Req   - request level from initiator
//                Cmd   - command (NOP/LOAD/INC/READ), valid while Req high
//                P     - load value, valid while Req high
//                Ack   - one-cycle acknowledge
//                Rdata - counter value after the command, valid with Ack
//                Err   - illegal LOAD flag, valid with Ack
//                Q     - live counter value
//  Revision    : 1.0 - initial release
// ============================================================================
module req_ack_responder
  import req_ack_pkg::*;
#(
  parameter int ACK_LAT = 1,
  parameter int WIDTH   = 4,
  parameter int MODULO  = 10
) (
  input  logic             CLK,
  input  logic             MR_n,
  input  logic             Req,
  input  logic [1:0]       Cmd,
  input  logic [WIDTH-1:0] P,
  output logic             Ack,
  output logic [WIDTH-1:0] Rdata,
  output logic             Err,
  output logic [WIDTH-1:0] Q
);

  localparam logic [WIDTH:0] c_mod = (WIDTH+1)'(MODULO);

  generate
    if (ACK_LAT != 1 && ACK_LAT != 2) begin : g_bad_ack_lat
      $error("req_ack_responder: ACK_LAT must be 1 or 2");
    end
    if (MODULO < 2 || MODULO > 2**WIDTH) begin : g_bad_modulo
      $error("req_ack_responder: MODULO must be in 2..2**WIDTH");
    end
  endgenerate

  state_e           r_state;
  state_e           w_state_nxt;
  cmd_e             r_cmd;
  logic [WIDTH-1:0] r_p;
  logic             r_ack;
  logic             r_err;

  logic             w_enter_ack;
  cmd_e             w_ex_cmd;
  logic [WIDTH-1:0] w_ex_p;
  logic             w_load;
  logic             w_inc;
  logic             w_load_bad;
  logic [WIDTH-1:0] w_q;

  // Next state. With ACK_LAT=1 the command executes on the very edge that
  // samples Req, so the live Cmd/P feed the counter; from WAIT the captured
  // copy is used because the inputs are no longer trusted.
  always_comb begin
    w_state_nxt = r_state;
    w_enter_ack = 1'b0;
    w_ex_cmd    = cmd_e'(Cmd);
    w_ex_p      = P;
    case (r_state)
      IDLE: begin
        if (Req) begin
          if (ACK_LAT == 1) begin
            w_state_nxt = ACK;
            w_enter_ack = 1'b1;
          end else begin
            w_state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        w_state_nxt = ACK;
        w_enter_ack = 1'b1;
        w_ex_cmd    = r_cmd;
        w_ex_p      = r_p;
      end
      ACK: begin
        // Req here is still the old request being held; ignore it.
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_load = w_enter_ack && (w_ex_cmd == LOAD);
  assign w_inc  = w_enter_ack && (w_ex_cmd == INC);

  always_ff @(posedge CLK or negedge MR_n) begin
    if (!MR_n) begin
      r_state <= IDLE;
      r_cmd   <= NOP;
      r_p     <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_enter_ack;
      r_err   <= w_load && w_load_bad;
      if (r_state == IDLE && Req) begin
        r_cmd <= cmd_e'(Cmd);
        r_p   <= P;
      end
    end
  end

  mod_counter #(
    .WIDTH  (WIDTH),
    .MODULO (MODULO)
  ) u_counter (
    .clk        (CLK),
    .rst_n      (MR_n),
    .i_load     (w_load),
    .i_inc      (w_inc),
    .i_d        (w_ex_p),
    .o_q        (w_q),
    .o_load_bad (w_load_bad)
  );

  // The counter only moves on the edge entering ACK, so during ACK its
  // register already holds the post-command value that Rdata must return.
  assign Ack   = r_ack;
  assign Err   = r_err;
  assign Q     = w_q;
  assign Rdata = w_q;

  a_ack_latency: assert property (@(posedge CLK) disable iff (!MR_n)
    (r_state == IDLE && Req) |-> ##ACK_LAT Ack);

  a_ack_pulse: assert property (@(posedge CLK) disable iff (!MR_n)
    Ack |=> !Ack);

  a_load_value: assert property (@(posedge CLK) disable iff (!MR_n)
    (Ack && r_cmd == LOAD && ({1'b0, r_p} < c_mod)) |-> (Q == r_p));

  a_q_range: assert property (@(posedge CLK) disable iff (!MR_n)
    ({1'b0, Q} < c_mod));

endmodule
`default_nettype wire

// File: tb/tb_req_ack_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_req_ack_responder
//  Description : Bench for req_ack_responder. Unit 0 is built with ACK_LAT=1,
//                unit 1 with ACK_LAT=2; both share clock and reset. Expected
//                results come from an arithmetic model of the counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_req_ack_responder;

  localparam int c_mod = 10;
  localparam int c_nop  = 0;
  localparam int c_load = 1;
  localparam int c_inc  = 2;
  localparam int c_read = 3;

  logic            clk;
  logic            mr_n;
  logic [1:0]      req;
  logic [1:0][1:0] cmd;
  logic [1:0][3:0] pv;
  logic [1:0]      ack;
  logic [1:0][3:0] rdata;
  logic [1:0]      err;
  logic [1:0][3:0] q;

  int n_checks;
  int n_errors;
  int qm[2];

  req_ack_responder #(.ACK_LAT(1), .WIDTH(4), .MODULO(c_mod)) u_dut_lat1 (
    .CLK   (clk),
    .MR_n  (mr_n),
    .Req   (req[0]),
    .Cmd   (cmd[0]),
    .P     (pv[0]),
    .Ack   (ack[0]),
    .Rdata (rdata[0]),
    .Err   (err[0]),
    .Q     (q[0])
  );

  req_ack_responder #(.ACK_LAT(2), .WIDTH(4), .MODULO(c_mod)) u_dut_lat2 (
    .CLK   (clk),
    .MR_n  (mr_n),
    .Req   (req[1]),
    .Cmd   (cmd[1]),
    .P     (pv[1]),
    .Ack   (ack[1]),
    .Rdata (rdata[1]),
    .Err   (err[1]),
    .Q     (q[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One full transaction on unit u (latency u+1). Inputs change on the
  // falling edge; outputs are sampled 1 ns after the rising edge.
  task automatic txn(input int u, input int c, input int p,
                     input bit corrupt, input bit keep);
    int lat;
    int exp_q;
    int exp_e;
    lat   = u + 1;
    exp_q = qm[u];
    exp_e = 0;
    if (c == c_load) begin
      if (p < c_mod) exp_q = p;
      else           exp_e = 1;
    end else if (c == c_inc) begin
      exp_q = (qm[u] + 1) % c_mod;
    end
    @(negedge clk);
    req[u] = 1'b1;
    cmd[u] = 2'(c);
    pv[u]  = 4'(p);
    @(posedge clk);
    if (lat == 2) begin
      #1;
      chk("wait_no_ack", 32'(ack[u]), 0);
      chk("wait_q_held", 32'(q[u]), 32'(qm[u]));
      @(negedge clk);
      if (corrupt) pv[u] = 4'($urandom_range(0, 15));
      @(posedge clk);
    end
    #1;
    chk("ack_high", 32'(ack[u]), 1);
    chk("rdata", 32'(rdata[u]), 32'(exp_q));
    chk("err", 32'(err[u]), 32'(exp_e));
    chk("q", 32'(q[u]), 32'(exp_q));
    qm[u] = exp_q;
    @(posedge clk);
    #1;
    chk("ack_drop", 32'(ack[u]), 0);
    chk("err_drop", 32'(err[u]), 0);
    if (!keep) begin
      @(negedge clk);
      req[u] = 1'b0;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    qm[0]    = 0;
    qm[1]    = 0;
    req      = '0;
    cmd      = '0;
    pv       = '0;
    mr_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("rst_ack", 32'(ack[u]), 0);
      chk("rst_rdata", 32'(rdata[u]), 0);
      chk("rst_err", 32'(err[u]), 0);
      chk("rst_q", 32'(q[u]), 0);
    end
    @(negedge clk);
    mr_n = 1'b1;

    // ACK_LAT=1 directed: READ after reset, LOAD 7 then back-to-back INCs
    txn(0, c_read, 0, 1'b0, 1'b0);
    txn(0, c_load, 7, 1'b0, 1'b1);
    txn(0, c_inc,  0, 1'b0, 1'b1);
    txn(0, c_inc,  0, 1'b0, 1'b1);
    txn(0, c_inc,  0, 1'b0, 1'b0);
    txn(0, c_load, 4, 1'b0, 1'b0);
    txn(0, c_load, 12, 1'b0, 1'b0);
    txn(0, c_nop,  0, 1'b0, 1'b0);

    // ACK_LAT=2 directed: P disturbed during WAIT must not affect LOAD
    txn(1, c_load, 3, 1'b1, 1'b0);
    txn(1, c_load, 9, 1'b1, 1'b1);
    txn(1, c_inc,  0, 1'b0, 1'b0);
    txn(1, c_load, 15, 1'b0, 1'b0);
    txn(1, c_load, 5, 1'b0, 1'b0);

    // Reset asserted while unit 1 sits in WAIT with Q=5
    @(negedge clk);
    req[1] = 1'b1;
    cmd[1] = 2'(c_inc);
    pv[1]  = 4'd0;
    @(posedge clk);
    #2;
    mr_n = 1'b0;
    #1;
    qm[0] = 0;
    qm[1] = 0;
    chk("mr_q_async", 32'(q[1]), 0);
    chk("mr_ack", 32'(ack[1]), 0);
    chk("mr_q_unit0", 32'(q[0]), 0);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("mr_hold_ack", 32'(ack[1]), 0);
    end
    @(negedge clk);
    req[1] = 1'b0;
    mr_n   = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("post_mr_no_ack", 32'(ack[1]), 0);
      chk("post_mr_q", 32'(q[1]), 0);
    end
    txn(1, c_read, 0, 1'b0, 1'b0);

    // Randomized traffic on each unit, sometimes back-to-back
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 25; i++) begin
        int  c;
        int  p;
        bit  keep;
        c    = int'($urandom_range(0, 3));
        p    = int'($urandom_range(0, 15));
        keep = (i != 24) && ($urandom_range(0, 1) == 1);
        txn(u, c, p, $urandom_range(0, 1) == 1, keep);
        if (!keep) repeat ($urandom_range(0, 2)) @(posedge clk);
      end
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/req_ack_responder.md
# req_ack_responder

Responder end of the single-clock Req/Ack command handshake: accepts a command from an initiator, executes it on an internal modulo counter, and returns Ack exactly ACK_LAT cycles after Req is sampled. It is the target-side partner of initiators checked by `Req |-> ##[1:2] Ack`. It embeds its own concurrent assertions so protocol and load correctness are checked in every simulation that instantiates it.

## Interface
- ACK_LAT, 1, cycles from Req sample to Ack sample; legal 1 or 2 (elaboration error otherwise)
- WIDTH, 4, counter/data width
- MODULO, 10, counter modulus; must satisfy 2 ≤ MODULO ≤ 2**WIDTH
- CLK  in  1  clock, rising-edge
- MR_n  in  1  master reset, asynchronous, active-low
- Req  in  1  request level from initiator
- Cmd  in  2  command: 00 NOP, 01 LOAD, 10 INC, 11 READ; valid while Req high
- P  in  WIDTH  load value; valid while Req high
- Ack  out  1  one-cycle acknowledge pulse
- Rdata  out  WIDTH  counter value after the command; valid while Ack high
- Err  out  1  illegal LOAD flag; valid while Ack high
- Q  out  WIDTH  live counter value

## Operation
- States: IDLE, WAIT (ACK_LAT=2 only), ACK.
- IDLE: Req=1 at an edge captures Cmd/P; go to ACK (ACK_LAT=1) or WAIT (ACK_LAT=2). Req=0: stay.
- WAIT: unconditionally go to ACK next edge; Req/Cmd/P ignored (captured copy used).
- Entering ACK (same edge): execute command, drive Ack=1, Rdata=result, Err per rule.
- ACK: next edge returns to IDLE, Ack=0; Req at that edge ignored (it is the initiator's old request).
- Commands: NOP — Q unchanged; LOAD — Q←P if P<MODULO, else Q unchanged and Err=1; INC — Q←(Q+1) mod MODULO (MODULO-1 wraps to 0); READ — Q unchanged.
- Rdata = Q after execution for all commands (including failed LOAD).
- Initiator rule: hold Req, Cmd, P stable until the edge at which Ack is sampled high. Req still high at the first edge after that is a new back-to-back request.
- Reset (MR_n low, any time, including in WAIT/ACK): state→IDLE, Q=0, Ack=0, Rdata=0, Err=0; in-flight transaction dropped with no Ack. Req is not sampled until the first rising edge after MR_n rises.
- Embedded assertions (disabled while !MR_n):
  - Req in IDLE |-> ##ACK_LAT Ack
  - Ack |=> !Ack
  - Ack && LOAD && P<MODULO |-> Q==P (no off-by-one)
  - Q < MODULO always

## Timing
- Latency: Req sampled at edge t → Ack, Rdata, Err, Q-update all visible after edge t+ACK_LAT-1 and sampled at edge t+ACK_LAT.
- Throughput: one transaction per ACK_LAT+1 cycles.
- All outputs are registered; no combinational path from inputs to outputs.
- Q changes only on edges that enter ACK, or asynchronously on reset.

## Structure
- Package req_ack_pkg: cmd_e enum (NOP, LOAD, INC, READ), state_e enum (IDLE, WAIT, ACK).
- One sub-module, mod_counter: WIDTH/MODULO counter with load/inc strobes and asynchronous active-low reset. Its outputs are Q and a load-illegal flag.
- FSM, capture registers and assertions live in req_ack_responder.

## Test plan
- Reset then READ (ACK_LAT=1): Req at edge 1 → Ack sampled at edge 2, Rdata=0, Err=0.
- LOAD P=7 → Q=7 and Rdata=7 with Ack. Follow with 3 back-to-back INC (Req held high) → Rdata 8, 9, 0, one Ack per 2 cycles.
- LOAD P=12 → Ack, Err=1, Q and Rdata keep their previous value.
- ACK_LAT=2 build: Req at edge t → Ack sampled exactly at t+2, never at t+1. Changing P during WAIT does not alter a LOAD result.
- MR_n pulsed low during WAIT with Q=5 → Ack never asserts, Q=0 immediately. Next Req after release gets a normal Ack.
- Negative check: force an off-by-one LOAD (Q←P+1) → load assertion fires at the Ack edge.
